// File: rtl/board_num_gen.sv
// ============================================================================
// board_num_gen : scans the mine map one cell per clock and stores saturated
//                 3-bit neighbour-mine counts into the array of the active level
// Revision      : 1.0
// ============================================================================
`default_nettype none

module board_num_gen #(
   parameter int HARD_SIZE = 16
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [1:0]                                    level,
   input  logic                                          start,
   input  logic [HARD_SIZE-1:0][HARD_SIZE-1:0]           mine_arr,
   output logic [7:0][7:0][2:0]                          num_arr_easy,
   output logic [9:0][9:0][2:0]                          num_arr_medium,
   output logic [HARD_SIZE-1:0][HARD_SIZE-1:0][2:0]      num_arr_hard,
   output logic                                          busy,
   output logic                                          done
);

   localparam int CW = $clog2(HARD_SIZE);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CLEAR  = 2'd1;
   localparam logic [1:0] S_SCAN   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [1:0] LVL_EASY   = 2'd1;
   localparam logic [1:0] LVL_MEDIUM = 2'd2;

   localparam logic [CW-1:0] LAST_EASY   = CW'(7);
   localparam logic [CW-1:0] LAST_MEDIUM = CW'(9);
   localparam logic [CW-1:0] LAST_HARD   = CW'(HARD_SIZE - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [1:0]    r_lvl;
   logic [CW-1:0] r_last;
   logic [CW-1:0] r_row;
   logic [CW-1:0] r_col;

   logic          w_accept;
   logic          w_last_cell;
   logic          w_busy_nxt;
   logic          w_done_nxt;

   logic          w_up_ok, w_dn_ok, w_lf_ok, w_rt_ok;
   logic [CW-1:0] w_rm, w_rp, w_cm, w_cp;
   logic [7:0]    w_nb;
   logic [3:0]    w_cnt;
   logic [2:0]    w_sat;

   assign w_accept    = start && (level != 2'd0);
   assign w_last_cell = (r_row == r_last) && (r_col == r_last);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_CLEAR;
         S_CLEAR:  w_state_nxt = S_SCAN;
         S_SCAN:   if (w_last_cell) w_state_nxt = S_FINISH;
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE:   w_busy_nxt = w_accept;
         S_CLEAR:  w_busy_nxt = 1'b1;
         S_SCAN:   w_busy_nxt = 1'b1;
         S_FINISH: w_done_nxt = 1'b1;
         default:  w_busy_nxt = 1'b0;
      endcase
   end

   // ------------------------------------------------- neighbour counting
   // Index arithmetic may wrap at the board edge; the *_ok gates (based on
   // the latched board size) discard those wrapped taps.
   assign w_up_ok = (r_row != '0);
   assign w_dn_ok = (r_row != r_last);
   assign w_lf_ok = (r_col != '0);
   assign w_rt_ok = (r_col != r_last);
   assign w_rm    = r_row - CW'(1);
   assign w_rp    = r_row + CW'(1);
   assign w_cm    = r_col - CW'(1);
   assign w_cp    = r_col + CW'(1);

   always_comb begin
      w_nb[0] = w_up_ok & w_lf_ok & mine_arr[w_rm][w_cm];
      w_nb[1] = w_up_ok           & mine_arr[w_rm][r_col];
      w_nb[2] = w_up_ok & w_rt_ok & mine_arr[w_rm][w_cp];
      w_nb[3] = w_lf_ok           & mine_arr[r_row][w_cm];
      w_nb[4] = w_rt_ok           & mine_arr[r_row][w_cp];
      w_nb[5] = w_dn_ok & w_lf_ok & mine_arr[w_rp][w_cm];
      w_nb[6] = w_dn_ok           & mine_arr[w_rp][r_col];
      w_nb[7] = w_dn_ok & w_rt_ok & mine_arr[w_rp][w_cp];
   end

   always_comb begin
      w_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_cnt = w_cnt + {3'b000, w_nb[i]};
      end
   end

   assign w_sat = w_cnt[3] ? 3'd7 : w_cnt[2:0];

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lvl          <= 2'd0;
         r_last         <= '0;
         r_row          <= '0;
         r_col          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         num_arr_easy   <= '0;
         num_arr_medium <= '0;
         num_arr_hard   <= '0;
      end else begin
         busy <= w_busy_nxt;
         done <= w_done_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_lvl  <= level;
                  r_last <= (level == LVL_EASY)   ? LAST_EASY :
                            (level == LVL_MEDIUM) ? LAST_MEDIUM : LAST_HARD;
               end
            end
            S_CLEAR: begin
               r_row <= '0;
               r_col <= '0;
               case (r_lvl)
                  LVL_EASY:   num_arr_easy   <= '0;
                  LVL_MEDIUM: num_arr_medium <= '0;
                  default:    num_arr_hard   <= '0;
               endcase
            end
            S_SCAN: begin
               case (r_lvl)
                  LVL_EASY:   num_arr_easy[r_row[2:0]][r_col[2:0]]   <= w_sat;
                  LVL_MEDIUM: num_arr_medium[r_row[3:0]][r_col[3:0]] <= w_sat;
                  default:    num_arr_hard[r_row][r_col]             <= w_sat;
               endcase
               if (r_col == r_last) begin
                  r_col <= '0;
                  r_row <= r_row + CW'(1);
               end else begin
                  r_col <= r_col + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_board_num_gen.sv
// ============================================================================
// tb_board_num_gen : directed + random checks of board_num_gen against a
//                    neighbour-count reference model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_board_num_gen;

   logic                     clk;
   logic                     rst;
   logic [1:0]               level;
   logic                     start;
   logic [15:0][15:0]        mine;
   logic [7:0][7:0][2:0]     ne;
   logic [9:0][9:0][2:0]     nm;
   logic [15:0][15:0][2:0]   nh;
   logic                     busy;
   logic                     done;

   logic [7:0][7:0][2:0]     xe;
   logic [9:0][9:0][2:0]     xm;
   logic [15:0][15:0][2:0]   xh;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   board_num_gen #(.HARD_SIZE(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .level          (level),
      .start          (start),
      .mine_arr       (mine),
      .num_arr_easy   (ne),
      .num_arr_medium (nm),
      .num_arr_hard   (nh),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_arrays(input string tag);
      chk_v({tag, "_easy"}, 768'(ne), 768'(xe));
      chk_v({tag, "_medium"}, 768'(nm), 768'(xm));
      chk_v({tag, "_hard"}, 768'(nh), 768'(xh));
   endtask

   // Mined neighbours inside an n x n board, capped at 7.
   function automatic int ref_cnt(input logic [15:0][15:0] m, input int n,
                                  input int r, input int c);
      int s = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < n &&
                c + dc >= 0 && c + dc < n) begin
               if (m[r + dr][c + dc]) s++;
            end
         end
      end
      return (s > 7) ? 7 : s;
   endfunction

   task automatic model_update(input int lvl, input logic [15:0][15:0] m);
      int n;
      n = (lvl == 1) ? 8 : (lvl == 2) ? 10 : 16;
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < n; c++) begin
            case (lvl)
               1:       xe[r][c] = 3'(ref_cnt(m, n, r, c));
               2:       xm[r][c] = 3'(ref_cnt(m, n, r, c));
               default: xh[r][c] = 3'(ref_cnt(m, n, r, c));
            endcase
         end
      end
   endtask

   task automatic run(input int lvl, input logic [15:0][15:0] m, input bit poke);
      int n, k, busy_cyc, d0;
      n  = (lvl == 1) ? 8 : (lvl == 2) ? 10 : 16;
      d0 = done_cnt;
      mine  = m;
      level = 2'(lvl);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_i("busy_after_start", int'(busy), 1);
      busy_cyc = busy ? 1 : 0;
      k = 0;
      while (!done && k < 400) begin
         if (poke && k == 20) begin
            start = 1'b1;
            level = (lvl == 3) ? 2'd1 : 2'd3;
         end
         if (poke && k == 22) start = 1'b0;
         @(posedge clk); #1;
         k++;
         if (busy) busy_cyc++;
      end
      start = 1'b0;
      chk_i("done_latency", k, n * n + 2);
      chk_i("busy_cycles", busy_cyc, n * n + 2);
      model_update(lvl, m);
      chk_arrays("result");
      @(posedge clk); #1;
      chk_i("done_width", int'(done), 0);
      chk_i("done_count", done_cnt - d0, 1);
   endtask

   logic [15:0][15:0] map;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      level = 2'd0;
      mine  = '0;
      xe = '0; xm = '0; xh = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_i("reset_busy", int'(busy), 0);
      chk_i("reset_done", int'(done), 0);
      chk_arrays("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Easy, lone mine in the corner
      map = '0; map[0][0] = 1'b1;
      run(1, map, 1'b0);
      chk_i("easy_01", int'(ne[0][1]), 1);
      chk_i("easy_11", int'(ne[1][1]), 1);
      chk_i("easy_00", int'(ne[0][0]), 0);

      // Medium, mines outside the 10x10 board must not leak in
      map = '0; map[4][4] = 1'b1; map[10] = '1;
      for (int r = 0; r < 16; r++) map[r][10] = 1'b1;
      run(2, map, 1'b0);
      chk_i("med_row9", int'(nm[9][5]), 0);
      chk_i("med_col9", int'(nm[5][9]), 0);
      chk_i("med_33", int'(nm[3][3]), 1);

      // Hard, fully mined
      map = '1;
      run(3, map, 1'b0);
      chk_i("hard_corner", int'(nh[15][0]), 3);
      chk_i("hard_edge", int'(nh[0][7]), 5);
      chk_i("hard_interior", int'(nh[8][8]), 7);

      // Easy empty map with a stray start mid-scan; hard array must persist
      map = '0;
      run(1, map, 1'b1);

      // start with level 0 is ignored
      begin
         int d0;
         d0 = done_cnt;
         level = 2'd0; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk_i("lvl0_busy", int'(busy), 0);
         repeat (4) @(posedge clk);
         #1;
         chk_i("lvl0_busy_later", int'(busy), 0);
         chk_i("lvl0_done_count", done_cnt - d0, 0);
         chk_arrays("lvl0");
      end

      // Reset sampled at the edge that would write hard cell 50
      begin
         int d0;
         d0 = done_cnt;
         for (int r = 0; r < 16; r++) map[r] = 16'($urandom);
         mine = map; level = 2'd3; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (51) @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         xe = '0; xm = '0; xh = '0;
         chk_i("rst_busy", int'(busy), 0);
         chk_i("rst_done", int'(done), 0);
         chk_arrays("rst_mid");
         @(posedge clk); #1;
         chk_i("rst_no_done", done_cnt - d0, 0);
         map = ~map;
         run(3, map, 1'b0);
      end

      // Random maps and levels
      for (int t = 0; t < 6; t++) begin
         for (int r = 0; r < 16; r++) map[r] = 16'($urandom) & 16'($urandom | $urandom);
         run(int'($urandom_range(1, 3)), map, t[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/board_num_gen.md
# board_num_gen

Producer of the per-cell neighbour-mine counts that the number-drawing path reads. After a game board is seeded with mines, this block scans the mine map one cell per clock. For every cell it counts mined neighbours and writes a 3-bit count into the array for the active difficulty level (`num_arr_easy`, `num_arr_medium` or `num_arr_hard`). It sits between the mine-placement logic and the board redraw path, and signals `done` once the full array is valid.

## Interface
Parameters:
- `HARD_SIZE`, 16: maximum board edge; sizes the `mine_arr` input and the hard array.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `level`  in  2: difficulty level.
  - 1 = easy (8x8), 2 = medium (10x10), 3 = hard (16x16).
  - 0 = no game.
- `start`  in  1: request a full recount; sampled only in IDLE.
- `mine_arr`  in  [15:0][15:0] bits: mine map, indexed `[row][col]`, 1 = mine.
- `num_arr_easy`  out  [7:0][7:0][2:0]: neighbour counts for the easy board.
- `num_arr_medium`  out  [9:0][9:0][2:0]: neighbour counts for the medium board.
- `num_arr_hard`  out  [15:0][15:0][2:0]: neighbour counts for the hard board.
- `busy`  out  1: high while a recount is in progress.
- `done`  out  1: one-cycle pulse when the recount completes.

## Operation
- FSM states: IDLE, CLEAR, SCAN, FINISH.
- IDLE:
  - On `start`=1 and `level`≠0: latch `level` into `lvl_q` and set board size N = 8, 10 or 16; go to CLEAR; `busy`←1.
  - `start` with `level`=0 is ignored.
- CLEAR:
  - Zero every element of the array selected by `lvl_q`.
  - Reset row/col counters to 0; go to SCAN.
- SCAN, one cell per cycle in row-major order (col increments, wraps at N-1, then row increments):
  - count = number of `mine_arr[r+dr][c+dc]` = 1 over the 8 neighbours, dr,dc ∈ {-1,0,1} excluding (0,0).
  - Neighbours with index <0 or ≥N are not counted. This uses the latched N, not 16, so mine bits outside the active board never contribute.
  - The cell's own mine bit is not counted. Mine cells still receive their neighbour count.
  - Count width is 4 bits internally. The stored value saturates: 8 is stored as 7.
  - Write the count to `arr[lvl_q][r][c]`.
  - After cell (N-1,N-1), go to FINISH.
- FINISH: `done`←1 for one cycle, `busy`←0, go to IDLE.
- Only the array of `lvl_q` is written. The other two arrays hold their values.
- `start` while not in IDLE is ignored. Changes to `level` after the latch are ignored.
- `mine_arr` must be stable from `start` until `done`. Results are undefined otherwise.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0.
  - All three arrays = 0; row/col counters = 0.
- Reset mid-scan takes effect on the next edge with the values above. No `done` pulse is issued.
- Cycle sequence, with `start` sampled at edge T:
  - Edge T: `busy`=1.
  - Edge T+1: CLEAR applied.
  - Edges T+2 … T+1+N²: cells (0,0) … (N-1,N-1) written, one per edge.
  - Edge T+2+N²: `done`=1 and `busy`=0.
  - Edge T+3+N²: `done`=0.
- Resulting busy duration, N²+2 cycles per level:
  - Easy: 66 cycles.
  - Medium: 102 cycles.
  - Hard: 258 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Array contents are valid for the reader when `done` is high, and afterwards until the next `start`.
- A new `start` is accepted on the edge after `done` (FSM back in IDLE).

## Test plan
- Easy, single mine at (0,0), start:
  - `num_arr_easy[0][1]`=`[1][0]`=`[1][1]`=1; all other cells 0.
  - `busy` high for exactly 66 cycles, then a single-cycle `done`.
- Medium, mine at (4,4) plus mines at row 10 and col 10 of `mine_arr`:
  - Only the 8 cells around (4,4) = 1; everything else 0, including row 9 and col 9.
  - Easy and hard arrays unchanged.
- Hard, all 256 mines set:
  - Corners = 3, edge non-corners = 5, interior = 7 (saturated from 8).
  - `done` at T+258.
- Hard full recount, then easy recount with an empty map:
  - Easy array all 0; hard array still holds its previous values.
  - Pulse `start` during busy → ignored; exactly one `done` per accepted start.
- Assert `rst` at SCAN cell 50 of a hard run:
  - Next cycle `busy`=0, all arrays 0, no `done`.
  - A `start` two cycles later completes normally.
- `start` with `level`=0: `busy` stays 0, arrays unchanged, no `done`.
